// File: rtl/pong_pkg.sv
// Shared Pong geometry: screen and paddle dimensions, the position type and
// the paddle movement command used by the paddle controller.
package pong_pkg;

    localparam int POS_W = 10;

    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;
    localparam int PADDLE_HEIGHT = 60;
    localparam int PADDLE_WIDTH  = 10;
    localparam int BALL_SIZE     = 10;
    localparam int PADDLE_X1     = 20;
    localparam int PADDLE_X2     = SCREEN_WIDTH - 20 - PADDLE_WIDTH;

    function automatic int max_y_of(input int screen_h, input int paddle_h);
        return screen_h - paddle_h;
    endfunction

    function automatic int center_of(input int screen_h, input int paddle_h);
        return (screen_h - paddle_h) / 2;
    endfunction

    localparam int MAX_Y  = max_y_of(SCREEN_HEIGHT, PADDLE_HEIGHT);
    localparam int CENTER = center_of(SCREEN_HEIGHT, PADDLE_HEIGHT);

    typedef logic [POS_W-1:0] pos_t;
    // One extra bit so AI target/centre sums cannot overflow.
    typedef logic [POS_W:0]   wide_pos_t;

    typedef enum logic [1:0] {
        MOVE_HOLD = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DN   = 2'd2
    } move_t;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser followed by a stability counter; the debounced output
// only follows the synced input after DEBOUNCE_CYCLES consecutive differing cycles.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_db
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;

    // synchroniser stages
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
        end
    end

    // stability counter / debounced value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            btn_db <= 1'b0;
        end else if (sync_p1 == btn_db) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt    <= '0;
            btn_db <= sync_p1;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/paddle_control.sv
// Paddle position controller: debounced buttons move each paddle on a slow tick,
// clamped to the screen. Define PADDLE_AI_EN to make paddle 2 track ball_y.
module paddle_control #(
    parameter int SCREEN_HEIGHT   = pong_pkg::SCREEN_HEIGHT,
    parameter int PADDLE_HEIGHT   = pong_pkg::PADDLE_HEIGHT,
    parameter int BALL_SIZE       = pong_pkg::BALL_SIZE,
    parameter int PADDLE_SPEED    = 2,
    parameter int TICK_DIV        = 250_000,
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int AI_DEADBAND     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       game_active,
    input  logic       game_over,
    input  logic       recenter,
    input  logic       btn_p1_up,
    input  logic       btn_p1_dn,
    input  logic       btn_p2_up,
    input  logic       btn_p2_dn,
    input  logic [9:0] ball_y,
    output logic [9:0] paddle1_y,
    output logic [9:0] paddle2_y,
    output logic       move_tick
);

    import pong_pkg::*;

    localparam pos_t CENTER_Y = pos_t'(center_of(SCREEN_HEIGHT, PADDLE_HEIGHT));
    localparam pos_t LIMIT_Y  = pos_t'(max_y_of(SCREEN_HEIGHT, PADDLE_HEIGHT));
    localparam pos_t STEP     = pos_t'(PADDLE_SPEED);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    logic              db_p1_up;
    logic              db_p1_dn;
    logic [TICK_W-1:0] tick_cnt;
    logic              move_ok;
    move_t             mv1;
    move_t             mv2;

    // Compare before subtracting/adding so the result never wraps.
    function automatic pos_t sat_up(input pos_t y);
        return (y < STEP) ? '0 : y - STEP;
    endfunction

    function automatic pos_t sat_dn(input pos_t y);
        return (y > LIMIT_Y - STEP) ? LIMIT_Y : y + STEP;
    endfunction

    function automatic move_t decode_btn(input logic up, input logic dn);
        if (up && !dn)
            return MOVE_UP;
        else if (dn && !up)
            return MOVE_DN;
        else
            return MOVE_HOLD;
    endfunction

    function automatic pos_t next_pos(input pos_t y, input move_t mv);
        case (mv)
            MOVE_UP: return sat_up(y);
            MOVE_DN: return sat_dn(y);
            default: return y;
        endcase
    endfunction

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_p1_up (
        .clk(clk), .reset(reset), .btn_raw(btn_p1_up), .btn_db(db_p1_up)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_p1_dn (
        .clk(clk), .reset(reset), .btn_raw(btn_p1_dn), .btn_db(db_p1_dn)
    );

`ifdef PADDLE_AI_EN
    localparam wide_pos_t HALF_BALL   = wide_pos_t'(BALL_SIZE / 2);
    localparam wide_pos_t HALF_PADDLE = wide_pos_t'(PADDLE_HEIGHT / 2);
    localparam wide_pos_t AI_BAND     = wide_pos_t'(AI_DEADBAND);

    wide_pos_t ai_target;
    wide_pos_t ai_centre;
    logic      unused_p2_btns;

    assign ai_target      = {1'b0, ball_y} + HALF_BALL;
    assign ai_centre      = {1'b0, paddle2_y} + HALF_PADDLE;
    assign unused_p2_btns = btn_p2_up ^ btn_p2_dn;

    always_comb begin
        mv2 = MOVE_HOLD;
        if (ai_target > ai_centre + AI_BAND)
            mv2 = MOVE_DN;
        else if (ai_target + AI_BAND < ai_centre)
            mv2 = MOVE_UP;
    end
`else
    logic db_p2_up;
    logic db_p2_dn;
    logic unused_ball_y;

    assign unused_ball_y = ^ball_y;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_p2_up (
        .clk(clk), .reset(reset), .btn_raw(btn_p2_up), .btn_db(db_p2_up)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_p2_dn (
        .clk(clk), .reset(reset), .btn_raw(btn_p2_dn), .btn_db(db_p2_dn)
    );

    always_comb begin
        mv2 = decode_btn(db_p2_up, db_p2_dn);
    end
`endif

    always_comb begin
        mv1 = decode_btn(db_p1_up, db_p1_dn);
    end

    // movement tick: free-running, independent of game state
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tick_cnt <= '0;
        else if (move_tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + TICK_W'(1);
    end

    assign move_tick = (tick_cnt == TICK_LAST);
    assign move_ok   = move_tick && game_active && !game_over;

    // position registers: recenter outranks movement
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            paddle1_y <= CENTER_Y;
            paddle2_y <= CENTER_Y;
        end else if (recenter) begin
            paddle1_y <= CENTER_Y;
            paddle2_y <= CENTER_Y;
        end else if (move_ok) begin
            paddle1_y <= next_pos(paddle1_y, mv1);
            paddle2_y <= next_pos(paddle2_y, mv2);
        end
    end

endmodule

// File: tb/tb_paddle_control.sv
// Self-checking bench for paddle_control with a short tick and debounce window.
module tb_paddle_control;

    localparam int TICK_DIV = 4;
    localparam int DEB      = 3;
    localparam int SPEED    = 2;

`ifdef PADDLE_AI_EN
    localparam bit P2_MANUAL = 1'b0;
`else
    localparam bit P2_MANUAL = 1'b1;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       game_active, game_over, recenter;
    logic       b1u, b1d, b2u, b2d;
    logic [9:0] ball_y;
    logic [9:0] p1, p2;
    logic       move_tick;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    paddle_control #(
        .PADDLE_SPEED(SPEED),
        .TICK_DIV(TICK_DIV),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk), .reset(reset),
        .game_active(game_active), .game_over(game_over), .recenter(recenter),
        .btn_p1_up(b1u), .btn_p1_dn(b1d), .btn_p2_up(b2u), .btn_p2_dn(b2d),
        .ball_y(ball_y),
        .paddle1_y(p1), .paddle2_y(p2), .move_tick(move_tick)
    );

    typedef struct {
        string name;
        int    exp1;
        int    exp2;
        bit    chk2;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        bit u1, d1, u2, d2, act, over;
        int k;
        int e1, e2;
    } vec_t;
    vec_t vt[9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic sb_push(input string name, input int e1, input int e2, input bit c2);
        sb_t e;
        e.name = name; e.exp1 = e1; e.exp2 = e2; e.chk2 = c2;
        sbq.push_back(e);
    endtask

    task automatic sb_check();
        sb_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = sbq.pop_front();
            chk({e.name, ".p1"}, int'(p1), e.exp1);
            if (e.chk2)
                chk({e.name, ".p2"}, int'(p2), e.exp2);
        end
    endtask

    // Advance to the next falling edge at which move_tick is visible.
    task automatic wait_tick();
        int n = 0;
        @(negedge clk);
        while (move_tick !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
        end
        if (move_tick !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout: got no move_tick expected one within %0d cycles", 12);
        end
    endtask

    task automatic set_btn(input bit u1, input bit d1, input bit u2, input bit d2);
        b1u = u1; b1d = d1; b2u = u2; b2d = d2;
    endtask

    task automatic recenter_pulse();
        recenter = 1'b1;
        @(negedge clk);
        recenter = 1'b0;
    endtask

    initial begin
        int last, tcnt, bad, y, c;

        // Each vector: press at a tick edge, hold k ticks (= k moves), release, idle 2 ticks.
        vt[0] = '{1, 0, 0, 0, 1, 0,   5, 200, 210};
        vt[1] = '{0, 0, 0, 1, 1, 0,   3, 200, 216};
        vt[2] = '{1, 1, 0, 0, 1, 0,   3, 200, 216};
        vt[3] = '{1, 0, 0, 1, 0, 0,   3, 200, 216};
        vt[4] = '{1, 0, 0, 1, 1, 1,   3, 200, 216};
        vt[5] = '{0, 1, 1, 0, 1, 0,   4, 208, 208};
        vt[6] = '{0, 1, 1, 1, 1, 0,   2, 212, 208};
        vt[7] = '{1, 0, 0, 0, 1, 0, 110,   0, 208};
        vt[8] = '{0, 0, 0, 1, 1, 0, 110,   0, 420};

        reset = 1'b1;
        game_active = 1'b0; game_over = 1'b0; recenter = 1'b0;
        set_btn(0, 0, 0, 0);
        ball_y = 10'd0;

        #3;
        chk("reset.p1", int'(p1), 210);
        chk("reset.p2", int'(p2), 210);
        chk("reset.move_tick", int'(move_tick), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        last = -1; tcnt = 0; bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (move_tick) begin
                if (last >= 0 && i - last != TICK_DIV) bad++;
                last = i;
                tcnt++;
            end
        end
        chk("idle.tick_count", tcnt, 5);
        chk("idle.tick_spacing_errors", bad, 0);
        chk("idle.p1", int'(p1), 210);
        chk("idle.p2", int'(p2), 210);

        for (int i = 0; i < 9; i++) begin
            wait_tick();
            game_active = vt[i].act;
            game_over   = vt[i].over;
            set_btn(vt[i].u1, vt[i].d1, vt[i].u2, vt[i].d2);
            sb_push($sformatf("vec%0d", i), vt[i].e1, vt[i].e2, P2_MANUAL);
            repeat (vt[i].k) wait_tick();
            set_btn(0, 0, 0, 0);
            repeat (2) wait_tick();
            sb_check();
        end

        game_active = 1'b1; game_over = 1'b0;
        recenter_pulse();
        sb_push("recenter_idle", 210, 210, 1'b1);
        sb_check();

        // Press on the tick-visible edge: debounced value lands on a tick edge, too late for it.
        wait_tick();
        b1u = 1'b1;
        repeat (5) @(negedge clk);
        chk("latA.before", int'(p1), 210);
        repeat (4) @(negedge clk);
        chk("latA.after", int'(p1), 208);
        b1u = 1'b0;
        repeat (4) wait_tick();
        recenter_pulse();

        // Press one cycle earlier: debounced value lands just before the tick edge.
        wait_tick();
        repeat (3) @(negedge clk);
        b1u = 1'b1;
        repeat (5) @(negedge clk);
        chk("latB.before", int'(p1), 210);
        @(negedge clk);
        chk("latB.after", int'(p1), 208);
        b1u = 1'b0;
        repeat (4) wait_tick();
        recenter_pulse();

        wait_tick();
        b1d = 1'b1;
        repeat (2) @(negedge clk);
        b1d = 1'b0;
        repeat (4) wait_tick();
        chk("glitch.p1", int'(p1), 210);

        wait_tick();
        set_btn(1, 0, 0, 1);
        repeat (3) wait_tick();
        chk("rc_tick.moving_p1", int'(p1), 208);
        chk("rc_tick.move_tick", int'(move_tick), 1);
        recenter_pulse();
        sb_push("rc_tick", 210, 210, 1'b1);
        sb_check();
        set_btn(0, 0, 0, 0);
        repeat (3) wait_tick();
        recenter_pulse();

`ifdef PADDLE_AI_EN
        ball_y = 10'd400;
        b2u = 1'b1;
        y = 210;
        while (400 + 5 > y + 30 + 4) y += SPEED;
        repeat (100) wait_tick();
        chk("ai_down.p2", int'(p2), y);
        chk("ai_down.p1", int'(p1), 210);
        ball_y = 10'd0;
        for (int i = 0; i < 300; i++)
            if (0 + 5 + 4 < y + 30) y = (y < SPEED) ? 0 : y - SPEED;
        repeat (250) wait_tick();
        chk("ai_up.p2", int'(p2), y);
        b2u = 1'b0;
        ball_y = 10'd0;
        recenter_pulse();
`endif

        wait_tick();
        b1u = 1'b1;
        repeat (3) wait_tick();
        chk("rst_mid.moving_p1", int'(p1), 208);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid.p1", int'(p1), 210);
        chk("rst_mid.p2", int'(p2), 210);
        chk("rst_mid.move_tick", int'(move_tick), 0);
        b1u = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        c = 0;
        while (move_tick !== 1'b1 && c < 10) begin
            @(negedge clk);
            c++;
        end
        chk("rst_mid.first_tick_cycles", c, TICK_DIV - 1);
        repeat (3) wait_tick();
        chk("rst_mid.no_move_after", int'(p1), 210);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
